serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder, the inverse companion of halfSubtractor. Adds two
//  unsigned operands one bit per clock, LSB first, through a full-adder cell
//  and a carry flip-flop. Offered as a start/busy/done unit to arithmetic
//  datapaths that trade latency for area; a result can be checked against
//  halfSubtractor-based subtraction (sum - b == a).
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk     input   1      rising-edge clock; only clock
//  rst     input   1      asynchronous, active-high reset
//  start   input   1      request; sampled on rising clk edge
//  a       input   WIDTH  addend; captured when start is accepted
//  b       input   WIDTH  addend; captured when start is accepted
//  busy    output  1      high while an addition is in progress
//  done    output  1      one-cycle pulse: sum/carry valid
//  sum     output  WIDTH  result bits a+b (mod 2^WIDTH); held until next accept
//  carry   output  1      carry-out of the MSB; held with sum
// BEHAVIOUR
//  - Reset: asynchronous, active-high, on one clock only. While rst=1: state=IDLE,
//    busy=0, done=0, sum=0, carry=0, bit counter=0, operand shift registers=0.
//  - FSM states: IDLE, RUN, DONE; all outputs registered.
//  - IDLE: start=1 at edge E0 -> capture a, b into shift regs, clear carry FF
//    and counter, go RUN; busy=1 from E0.
//  - RUN, each edge: s=a0^b0^c; c'=(a0&b0)|(c&(a0^b0)); shift s into sum MSB
//    side (sum>>1 | s<<(WIDTH-1)); shift both operand regs right one bit;
//    counter+1.
//  - After WIDTH RUN edges (edge E0+WIDTH): go DONE; busy=0, done=1, carry=final c,
//    sum = full result. Latency: done high in the cycle after edge E0+WIDTH.
//  - DONE lasts one cycle: done falls at next edge; go IDLE, or RUN if start=1
//    on that edge (back-to-back, new operands captured, same rules as IDLE).
//  - start during RUN is ignored; operands are not re-sampled and the result is
//    unaffected. a/b may change freely after acceptance.
//  - sum/carry keep the last result through IDLE; they hold the partial result
//    during RUN, and only the value shown while done=1 is valid.
//  - Wrap-around: the result is modulo 2^WIDTH; overflow is shown only on carry.
//  - Reset mid-RUN: the operation is abandoned, all outputs go to reset values
//    at once, and done is not pulsed.
//  - Counter width is clog2(WIDTH)+1. No combinational path from inputs to outputs.
// TESTING (WIDTH=8)
//  1. a=3,b=5, start 1 cycle -> busy 8 cycles; done pulse 8 cycles after accept;
//     sum=8, carry=0.
//  2. a=255,b=1 -> sum=0, carry=1; a=200,b=100 -> sum=44, carry=1.
//  3. Accept a=10,b=20; pulse start with a=99,b=99 in RUN cycle 3 -> sum=30,
//     carry=0, exactly one done pulse.
//  4. Hold start=1 continuously, operands 1+1 then 7+9 -> done pulses every
//     9 cycles; sums 2 then 16.
//  5. Assert rst in RUN cycle 4 of 100+100 -> busy=0, sum=0, carry=0 at once;
//     no done; a later 100+100 gives sum=200, carry=0.
//  6. 256 random a,b pairs -> {carry,sum} == a+b; done width 1 cycle each.

Source files
------------

// File: rtl/serial_adder_if.sv
// Request/response bundle for the bit-serial adder: operands and start in,
// busy/done status and the registered result out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output start, a, b,
        input  busy, done, sum, carry
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flip-flop, fed
// LSB first from two operand shift registers over WIDTH clocks.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_adder: WIDTH must be within 2..32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (ci & (x ^ y));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));

        case (state_q)
            // DONE accepts a new request exactly like IDLE, giving back-to-back operation
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                sum_d   = {fa_sum(a_q[0], b_q[0], carry_q), sum_q[WIDTH-1:1]};
                carry_d = fa_carry(a_q[0], b_q[0], carry_q);
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
endmodule
